// File: rtl/anabellek_denetleyici_pkg.sv
// Shared widths, FSM encoding and word-offset helpers for the main-memory controller
// and the cache controllers that talk to it.
package anabellek_denetleyici_pkg;

    localparam int ADRES_BIT     = 32;
    localparam int VERI_BIT      = 32;
    localparam int BLOK_BIT      = 128;
    localparam int KELIME_SAYISI = BLOK_BIT / VERI_BIT;

    localparam logic [1:0]           SON_KELIME  = 2'(KELIME_SAYISI - 1);
    localparam logic [ADRES_BIT-1:0] BLOK_MASKE  = ~ADRES_BIT'(BLOK_BIT / 8 - 1);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        AKTAR = 2'd1,
        CEVAP = 2'd2
    } durum_t;

    // Bit offset of word k inside a block.
    function automatic logic [6:0] kelime_ofs(input logic [1:0] k);
        return 7'(k) * 7'(VERI_BIT);
    endfunction

endpackage

// File: rtl/anabellek_denetleyici_hakem.sv
// Two-way round-robin arbiter between the instruction and data caches.
// son_v remembers whether the last grant went to the data cache.
module anabellek_hakem (
    input  logic clk_i,
    input  logic rst_i,
    input  logic etkin_i,
    input  logic b_gecerli_i,
    input  logic v_gecerli_i,
    output logic verildi_o,
    output logic v_sec_o
);

    logic son_v_q, son_v_d;

    always_comb begin
        v_sec_o   = v_gecerli_i & (~b_gecerli_i | ~son_v_q);
        verildi_o = etkin_i & (b_gecerli_i | v_gecerli_i);
        son_v_d   = verildi_o ? v_sec_o : son_v_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            son_v_q <= 1'b0;
        end else begin
            son_v_q <= son_v_d;
        end
    end

endmodule

// File: rtl/anabellek_denetleyici.sv
// Main-memory controller: arbitrates two cache block ports and splits each block
// into four word transactions on the memory bus.
//
//   state | meaning
//   BOSTA | idle, arbitrate and latch a request
//   AKTAR | word transfers on the memory bus, kelime selects the word
//   CEVAP | one-cycle hazir pulse to the granted cache
module anabellek_denetleyici
    import anabellek_denetleyici_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] b_okuma_istek_adres_i,
    input  logic                 b_okuma_istek_gecerli_i,
    output logic [BLOK_BIT-1:0]  b_okuma_veri_blok_o,
    output logic                 b_okuma_istek_hazir_o,
    input  logic [ADRES_BIT-1:0] v_istek_adres_i,
    input  logic                 v_istek_gecerli_i,
    input  logic                 v_istek_yaz_i,
    input  logic [BLOK_BIT-1:0]  v_yazma_veri_blok_i,
    output logic [BLOK_BIT-1:0]  v_okuma_veri_blok_o,
    output logic                 v_istek_hazir_o,
    output logic [ADRES_BIT-1:0] bellek_istek_adres_o,
    output logic                 bellek_istek_gecerli_o,
    output logic                 bellek_istek_yaz_o,
    output logic [VERI_BIT-1:0]  bellek_yazma_veri_o,
    input  logic [VERI_BIT-1:0]  bellek_okuma_veri_i,
    input  logic                 bellek_cevap_gecerli_i
);

    durum_t                durum_q, durum_d;
    logic [1:0]            kelime_q, kelime_d;
    logic [ADRES_BIT-1:0]  adres_q, adres_d;
    logic                  yaz_q, yaz_d;
    logic                  v_sec_q, v_sec_d;
    logic [BLOK_BIT-1:0]   blok_q, blok_d;
    logic [BLOK_BIT-1:0]   b_blok_q, b_blok_d;
    logic [BLOK_BIT-1:0]   v_blok_q, v_blok_d;
    logic [BLOK_BIT-1:0]   blok_yeni;
    logic                  verildi, v_sec;
    logic                  aktar;

    anabellek_hakem u_hakem (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .etkin_i     (durum_q == BOSTA),
        .b_gecerli_i (b_okuma_istek_gecerli_i),
        .v_gecerli_i (v_istek_gecerli_i),
        .verildi_o   (verildi),
        .v_sec_o     (v_sec)
    );

    always_comb begin
        durum_d  = durum_q;
        kelime_d = kelime_q;
        adres_d  = adres_q;
        yaz_d    = yaz_q;
        v_sec_d  = v_sec_q;
        blok_d   = blok_q;
        b_blok_d = b_blok_q;
        v_blok_d = v_blok_q;

        blok_yeni = blok_q;
        blok_yeni[kelime_ofs(kelime_q) +: VERI_BIT] = bellek_okuma_veri_i;

        unique case (durum_q)
            BOSTA: begin
                if (verildi) begin
                    durum_d  = AKTAR;
                    kelime_d = '0;
                    v_sec_d  = v_sec;
                    if (v_sec) begin
                        adres_d = v_istek_adres_i & BLOK_MASKE;
                        yaz_d   = v_istek_yaz_i;
                        blok_d  = v_yazma_veri_blok_i;
                    end else begin
                        adres_d = b_okuma_istek_adres_i & BLOK_MASKE;
                        yaz_d   = 1'b0;
                    end
                end
            end
            AKTAR: begin
                if (bellek_cevap_gecerli_i) begin
                    kelime_d = kelime_q + 2'd1;
                    if (!yaz_q) begin
                        blok_d = blok_yeni;
                    end
                    if (kelime_q == SON_KELIME) begin
                        durum_d = CEVAP;
                        // Publish the finished block so it is valid during the hazir cycle.
                        if (!yaz_q) begin
                            if (v_sec_q) begin
                                v_blok_d = blok_yeni;
                            end else begin
                                b_blok_d = blok_yeni;
                            end
                        end
                    end
                end
            end
            CEVAP: begin
                durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q  <= BOSTA;
            kelime_q <= '0;
            adres_q  <= '0;
            yaz_q    <= 1'b0;
            v_sec_q  <= 1'b0;
            blok_q   <= '0;
            b_blok_q <= '0;
            v_blok_q <= '0;
        end else begin
            durum_q  <= durum_d;
            kelime_q <= kelime_d;
            adres_q  <= adres_d;
            yaz_q    <= yaz_d;
            v_sec_q  <= v_sec_d;
            blok_q   <= blok_d;
            b_blok_q <= b_blok_d;
            v_blok_q <= v_blok_d;
        end
    end

    assign aktar = (durum_q == AKTAR);

    always_comb begin
        bellek_istek_gecerli_o = aktar;
        bellek_istek_adres_o   = aktar ? (adres_q | ADRES_BIT'({kelime_q, 2'b00})) : '0;
        bellek_istek_yaz_o     = aktar & yaz_q;
        bellek_yazma_veri_o    = (aktar && yaz_q) ? blok_q[kelime_ofs(kelime_q) +: VERI_BIT] : '0;
        b_okuma_istek_hazir_o  = (durum_q == CEVAP) & ~v_sec_q;
        v_istek_hazir_o        = (durum_q == CEVAP) & v_sec_q;
        b_okuma_veri_blok_o    = b_blok_q;
        v_okuma_veri_blok_o    = v_blok_q;
    end

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Bench for anabellek_denetleyici: table vectors, hand-written corner sequences and
// randomized transactions against a word-addressed memory model.
module tb_anabellek_denetleyici;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  b_adres;
    logic         b_gecerli;
    logic [127:0] b_blok;
    logic         b_hazir;
    logic [31:0]  v_adres;
    logic         v_gecerli;
    logic         v_yaz;
    logic [127:0] v_wblok;
    logic [127:0] v_blok;
    logic         v_hazir;
    logic [31:0]  m_adres;
    logic         m_gecerli;
    logic         m_yaz;
    logic [31:0]  m_wveri;
    logic [31:0]  rveri;
    logic         cevap;

    always #5 clk = ~clk;

    anabellek_denetleyici dut (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .b_okuma_istek_adres_i   (b_adres),
        .b_okuma_istek_gecerli_i (b_gecerli),
        .b_okuma_veri_blok_o     (b_blok),
        .b_okuma_istek_hazir_o   (b_hazir),
        .v_istek_adres_i         (v_adres),
        .v_istek_gecerli_i       (v_gecerli),
        .v_istek_yaz_i           (v_yaz),
        .v_yazma_veri_blok_i     (v_wblok),
        .v_okuma_veri_blok_o     (v_blok),
        .v_istek_hazir_o         (v_hazir),
        .bellek_istek_adres_o    (m_adres),
        .bellek_istek_gecerli_o  (m_gecerli),
        .bellek_istek_yaz_o      (m_yaz),
        .bellek_yazma_veri_o     (m_wveri),
        .bellek_okuma_veri_i     (rveri),
        .bellek_cevap_gecerli_i  (cevap)
    );

    typedef struct {
        logic [31:0] adr;
        logic        yaz;
        logic [31:0] veri;
        int          sure;
    } kayit_t;

    typedef struct {
        bit           vt;
        bit           yz;
        logic [31:0]  adres;
        logic [127:0] wblok;
        logic [127:0] oblok;
        int           bk;
        int           bn;
        int           lat;
    } vektor_t;

    int gecen = 0;
    int toplam = 0;
    int b_say = 0;
    int v_say = 0;
    logic [31:0] mem [logic [31:0]];
    kayit_t log_q[$];
    int  bk = -1;
    int  bn = 0;
    bit  rastgele = 1'b0;
    bit  yeni = 1'b1;
    int  kalan = 0;
    int  sure = 0;

    function automatic logic [31:0] oku(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [127:0] oku_blok(input logic [31:0] a);
        logic [127:0] r;
        logic [31:0]  taban;
        taban = {a[31:4], 4'h0};
        for (int i = 0; i < 4; i++) r[32*i +: 32] = oku(taban + 32'(4*i));
        return r;
    endfunction

    function automatic logic [383:0] cikis_vektor();
        return 384'({b_blok, v_blok, b_hazir, v_hazir, m_adres, m_gecerli, m_yaz, m_wveri});
    endfunction

    task automatic kontrol(input string ad, input logic [383:0] gercek, input logic [383:0] beklenen);
        toplam++;
        if (gercek === beklenen) gecen++;
        else $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
    endtask

    // Memory responder: per-word wait states, then data/ack in the same cycle.
    always @(negedge clk) begin
        if (rst_i || !m_gecerli) begin
            cevap = 1'b0;
            yeni  = 1'b1;
        end else begin
            if (yeni) begin
                kalan = rastgele ? int'($urandom_range(0, 2)) : ((int'(m_adres[3:2]) == bk) ? bn : 0);
                sure  = 0;
                yeni  = 1'b0;
            end
            sure++;
            if (kalan == 0) begin
                cevap = 1'b1;
                rveri = oku(m_adres);
                if (m_yaz) mem[m_adres] = m_wveri;
                log_q.push_back('{m_adres, m_yaz, m_wveri, sure});
                yeni = 1'b1;
            end else begin
                cevap = 1'b0;
                kalan--;
            end
        end
    end

    always @(posedge clk) begin
        if (b_hazir) b_say++;
        if (v_hazir) v_say++;
    end

    task automatic log_kontrol(input string ad, input logic [31:0] adres, input bit yz,
                               input logic [127:0] wb, input int k, input int n, input bit sure_bak);
        logic [127:0] adrs, veris, e_adrs;
        logic [3:0]   yazs;
        logic [31:0]  sures, e_sures;
        kayit_t       e;
        kontrol({ad, "_kelime_sayisi"}, 384'(log_q.size() >= 4), 384'(1));
        if (log_q.size() < 4) return;
        for (int i = 0; i < 4; i++) begin
            e = log_q.pop_front();
            adrs[32*i +: 32]  = e.adr;
            e_adrs[32*i +: 32] = {adres[31:4], 4'h0} + 32'(4*i);
            veris[32*i +: 32] = e.veri;
            yazs[i]           = e.yaz;
            sures[8*i +: 8]   = 8'(e.sure);
            e_sures[8*i +: 8] = 8'(1 + ((i == k) ? n : 0));
        end
        kontrol({ad, "_adresler"}, 384'(adrs), 384'(e_adrs));
        kontrol({ad, "_yaz"}, 384'(yazs), yz ? 384'(4'hF) : 384'(0));
        if (yz) kontrol({ad, "_yazma_veri"}, 384'(veris), 384'(wb));
        if (sure_bak) kontrol({ad, "_bekleme"}, 384'(sures), 384'(e_sures));
    endtask

    task automatic istek(input bit vt, input bit yz, input logic [31:0] adr, input logic [127:0] wb,
                         output int lat, output logic [127:0] blk, output time t);
        bit gor = 1'b0;
        lat = -1;
        blk = '0;
        t   = 0;
        if (vt) begin
            v_adres = adr; v_yaz = yz; v_wblok = wb; v_gecerli = 1'b1;
        end else begin
            b_adres = adr; b_gecerli = 1'b1;
        end
        for (int i = 1; i <= 60 && !gor; i++) begin
            @(negedge clk);
            if (vt ? v_hazir : b_hazir) begin
                gor = 1'b1;
                lat = i;
                blk = vt ? v_blok : b_blok;
                t   = $time;
            end
        end
        if (vt) v_gecerli = 1'b0;
        else    b_gecerli = 1'b0;
        if (!gor) kontrol(vt ? "v_zaman_asimi" : "b_zaman_asimi", 384'(0), 384'(1));
        @(negedge clk);
    endtask

    task automatic sifirla();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        log_q.delete();
    endtask

    vektor_t      tablo [6];
    int           lat, lat2, b0, v0;
    logic [127:0] blk, blk2, bek, bek2;
    time          t_b, t_v;
    bit           gor;

    initial begin
        rst_i = 1'b1; b_adres = '0; b_gecerli = 1'b0;
        v_adres = '0; v_gecerli = 1'b0; v_yaz = 1'b0; v_wblok = '0;
        rveri = '0; cevap = 1'b0;

        repeat (3) @(negedge clk);
        kontrol("sifirlama_cikislar", cikis_vektor(), 384'(0));
        rst_i = 1'b0;
        @(negedge clk);
        kontrol("sifirlama_sonrasi_bosta", cikis_vektor(), 384'(0));

        mem[32'h1230] = 32'h11; mem[32'h1234] = 32'h22;
        mem[32'h1238] = 32'h33; mem[32'h123C] = 32'h44;
        mem[32'h200]  = 32'h5;  mem[32'h204]  = 32'h6;
        mem[32'h208]  = 32'h7;  mem[32'h20C]  = 32'h8;

        tablo[0] = '{1'b0, 1'b0, 32'h0000_1234, 128'h0,
                     128'h00000044_00000033_00000022_00000011, -1, 0, 5};
        tablo[1] = '{1'b1, 1'b1, 32'h0000_0100, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA,
                     128'h0, -1, 0, 5};
        tablo[2] = '{1'b1, 1'b0, 32'h0000_0100, 128'h0,
                     128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, -1, 0, 5};
        tablo[3] = '{1'b0, 1'b0, 32'h0000_1238, 128'h0,
                     128'h00000044_00000033_00000022_00000011, 2, 3, 8};
        tablo[4] = '{1'b1, 1'b0, 32'h0000_020F, 128'h0,
                     128'h00000008_00000007_00000006_00000005, 0, 2, 7};
        tablo[5] = '{1'b0, 1'b0, 32'h0000_0100, 128'h0,
                     128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, -1, 0, 5};

        for (int i = 0; i < 6; i++) begin
            bk = tablo[i].bk;
            bn = tablo[i].bn;
            b0 = b_say;
            v0 = v_say;
            istek(tablo[i].vt, tablo[i].yz, tablo[i].adres, tablo[i].wblok, lat, blk, t_b);
            kontrol($sformatf("t%0d_gecikme", i), 384'(lat), 384'(tablo[i].lat));
            if (!tablo[i].yz) kontrol($sformatf("t%0d_blok", i), 384'(blk), 384'(tablo[i].oblok));
            kontrol($sformatf("t%0d_b_hazir_darbe", i), 384'(b_say - b0), 384'(tablo[i].vt ? 0 : 1));
            kontrol($sformatf("t%0d_v_hazir_darbe", i), 384'(v_say - v0), 384'(tablo[i].vt ? 1 : 0));
            log_kontrol($sformatf("t%0d", i), tablo[i].adres, tablo[i].yz, tablo[i].wblok,
                        tablo[i].bk, tablo[i].bn, 1'b1);
        end
        bk = -1;
        bn = 0;

        // Ties: data wins after reset, then instruction wins after a data grant.
        sifirla();
        bek  = oku_blok(32'h100);
        bek2 = oku_blok(32'h1234);
        fork
            istek(1'b1, 1'b0, 32'h100, 128'h0, lat, blk, t_v);
            istek(1'b0, 1'b0, 32'h1234, 128'h0, lat2, blk2, t_b);
        join
        kontrol("esit1_v_once", 384'(t_v < t_b), 384'(1));
        kontrol("esit1_v_blok", 384'(blk), 384'(bek));
        kontrol("esit1_b_blok", 384'(blk2), 384'(bek2));
        log_kontrol("esit1_v", 32'h100, 1'b0, 128'h0, -1, 0, 1'b1);
        log_kontrol("esit1_b", 32'h1234, 1'b0, 128'h0, -1, 0, 1'b1);

        istek(1'b1, 1'b0, 32'h200, 128'h0, lat, blk, t_v);
        log_kontrol("esit2_on", 32'h200, 1'b0, 128'h0, -1, 0, 1'b1);
        b0 = b_say;
        v0 = v_say;
        fork
            istek(1'b1, 1'b0, 32'h200, 128'h0, lat, blk, t_v);
            istek(1'b0, 1'b0, 32'h1230, 128'h0, lat2, blk2, t_b);
        join
        kontrol("esit2_b_once", 384'(t_b < t_v), 384'(1));
        kontrol("esit2_darbeler", 384'({b_say - b0, v_say - v0}), 384'({32'd1, 32'd1}));
        log_kontrol("esit2_b", 32'h1230, 1'b0, 128'h0, -1, 0, 1'b1);
        log_kontrol("esit2_v", 32'h200, 1'b0, 128'h0, -1, 0, 1'b1);

        // Requester keeps valid one cycle past hazir: a second transaction must follow.
        bek = oku_blok(32'h1230);
        b0 = b_say;
        b_adres = 32'h1230;
        b_gecerli = 1'b1;
        gor = 1'b0;
        for (int i = 0; i < 60 && !gor; i++) begin
            @(negedge clk);
            gor = b_hazir;
        end
        kontrol("tut_ilk_hazir", 384'(gor), 384'(1));
        @(negedge clk);
        @(negedge clk);
        b_gecerli = 1'b0;
        gor = 1'b0;
        blk = '0;
        for (int i = 0; i < 60 && !gor; i++) begin
            @(negedge clk);
            if (b_hazir) begin
                gor = 1'b1;
                blk = b_blok;
            end
        end
        kontrol("tut_ikinci_hazir", 384'(gor), 384'(1));
        kontrol("tut_ikinci_blok", 384'(blk), 384'(bek));
        repeat (8) @(negedge clk);
        kontrol("tut_darbe_sayisi", 384'(b_say - b0), 384'(2));
        log_kontrol("tut_1", 32'h1230, 1'b0, 128'h0, -1, 0, 1'b1);
        log_kontrol("tut_2", 32'h1230, 1'b0, 128'h0, -1, 0, 1'b1);

        // Reset during word 1 of a read aborts it without a hazir pulse.
        b0 = b_say;
        b_adres = 32'h3000;
        b_gecerli = 1'b1;
        @(negedge clk);
        @(negedge clk);
        kontrol("sifir_kelime1_adres", 384'({m_gecerli, m_adres}), 384'({1'b1, 32'h3004}));
        rst_i = 1'b1;
        b_gecerli = 1'b0;
        @(negedge clk);
        kontrol("sifir_cikislar", cikis_vektor(), 384'(0));
        rst_i = 1'b0;
        log_q.delete();
        repeat (10) @(negedge clk);
        kontrol("sifir_hazir_yok", 384'(b_say - b0), 384'(0));
        kontrol("sifir_log_bos", 384'(log_q.size()), 384'(0));
        bek = oku_blok(32'h3000);
        istek(1'b0, 1'b0, 32'h3000, 128'h0, lat, blk, t_b);
        kontrol("sifir_sonra_gecikme", 384'(lat), 384'(5));
        kontrol("sifir_sonra_blok", 384'(blk), 384'(bek));
        log_kontrol("sifir_sonra", 32'h3000, 1'b0, 128'h0, -1, 0, 1'b1);

        // Randomized traffic with random wait states.
        rastgele = 1'b1;
        for (int n = 0; n < 40; n++) begin
            bit           vt, yz;
            logic [31:0]  adr;
            logic [127:0] wb;
            vt  = 1'($urandom_range(0, 1));
            yz  = vt & 1'($urandom_range(0, 1));
            adr = 32'h4000 + 32'($urandom_range(0, 15) << 4) + 32'($urandom_range(0, 15));
            wb  = {$urandom, $urandom, $urandom, $urandom};
            bek = oku_blok(adr);
            b0  = b_say;
            v0  = v_say;
            istek(vt, yz, adr, wb, lat, blk, t_b);
            if (!yz) kontrol($sformatf("r%0d_blok", n), 384'(blk), 384'(bek));
            kontrol($sformatf("r%0d_darbeler", n), 384'({b_say - b0, v_say - v0}),
                    384'({vt ? 32'd0 : 32'd1, vt ? 32'd1 : 32'd0}));
            log_kontrol($sformatf("r%0d", n), adr, yz, wb, -1, 0, 1'b0);
            if (yz) kontrol($sformatf("r%0d_bellek", n), 384'(oku_blok(adr)), 384'(wb));
        end

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", gecen, toplam);
        $fatal(1);
    end

endmodule

// File: doc/anabellek_denetleyici.md
# anabellek_denetleyici

Main-memory controller: the responder end of the block-read interface driven by the instruction cache controller, plus a block read/write port for the data cache controller. It arbitrates between the two caches and splits each 128-bit block transfer into four sequential 32-bit word transactions on the main-memory bus. It then returns the assembled block, or a write acknowledge, with a one-cycle ready pulse.

## Interface
- ADRES_BIT, 32, address width
- VERI_BIT, 32, memory word width
- BLOK_BIT, 128, cache block width (BLOK_BIT/VERI_BIT = 4 words)

Reset is synchronous and active-high.

- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- b_okuma_istek_adres_i  in  ADRES_BIT  instruction-cache block read address
- b_okuma_istek_gecerli_i  in  1  instruction-cache read request
- b_okuma_veri_blok_o  out  BLOK_BIT  block returned to instruction cache
- b_okuma_istek_hazir_o  out  1  one-cycle pulse: block valid
- v_istek_adres_i  in  ADRES_BIT  data-cache block address
- v_istek_gecerli_i  in  1  data-cache request
- v_istek_yaz_i  in  1  1 = block write, 0 = block read
- v_yazma_veri_blok_i  in  BLOK_BIT  write block
- v_okuma_veri_blok_o  out  BLOK_BIT  block returned to data cache
- v_istek_hazir_o  out  1  one-cycle pulse: read block valid or write done
- bellek_istek_adres_o  out  ADRES_BIT  word address to memory
- bellek_istek_gecerli_o  out  1  word request valid
- bellek_istek_yaz_o  out  1  word write enable
- bellek_yazma_veri_o  out  VERI_BIT  word write data
- bellek_okuma_veri_i  in  VERI_BIT  word read data
- bellek_cevap_gecerli_i  in  1  word done (read data valid / write accepted)

## Operation
- States: BOSTA, AKTAR, CEVAP.
- BOSTA: samples both request valids.
  - If exactly one is high, it is granted.
  - If both are high, the side not granted last time wins (round-robin bit `son_v`; reset value 0, so the data cache wins the first tie).
  - On grant, latch the address with bits [3:0] forced to 0, the requester identity, the write flag, and the write block. Clear word counter `kelime` (2 bit). Go to AKTAR.
- AKTAR: bellek_istek_gecerli_o=1.
  - bellek_istek_adres_o = {adres[31:4], kelime, 2'b00}.
  - For writes: bellek_istek_yaz_o=1 and bellek_yazma_veri_o = blok[32*kelime+31 : 32*kelime].
  - On each cycle with bellek_cevap_gecerli_i=1, store the read word into blok[32*kelime+31 : 32*kelime] and increment `kelime`.
  - On the response with kelime==3, go to CEVAP.
- CEVAP: pulse the granted side's hazir for exactly one cycle. Its block output holds the assembled block in that cycle. Go to BOSTA. Request valids are ignored in this state.
- Requesters hold address and valid until they see hazir, and deassert valid at the edge where hazir is seen. The next BOSTA cycle re-samples, so a valid still held there starts a new transaction.
- Block outputs are registered and hold their last value between pulses. Only the hazir pulse qualifies them.
- bellek_cevap_gecerli_i outside AKTAR is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - State BOSTA, `kelime`=0, `son_v`=0, and internal block register 0.
- All outputs are driven from registers or from state/counter registers only. There is no combinational input-to-output path.
- Request accepted at edge N: bellek_istek_gecerli_o high from cycle N+1.
- With memory responding in the same cycle as valid, words complete at cycles N+1..N+4, hazir is high in cycle N+5, and BOSTA is reached at N+6. Minimum latency is therefore 5 cycles from acceptance to hazir.
- Memory wait states extend AKTAR. Address and write data stay stable while waiting.
- Reset mid-transaction aborts it: no hazir is issued, bellek_istek_gecerli_o is 0 after the reset edge, and the partial block is discarded.
- Unaligned request address: the low 4 bits are ignored and the whole containing block is transferred.

## Structure
- Shared package/header holds ADRES_BIT, VERI_BIT, BLOK_BIT, state encodings, and word offset constants. These widths are common with both cache controllers.
- Optional sub-module `anabellek_hakem`: round-robin two-way arbiter (grant + `son_v` update). Everything else is inline.

## Test plan
- Instruction read at 0x0000_1234 with a 0-wait memory returning 0x11,0x22,0x33,0x44 -> word addresses 0x1230, 0x1234, 0x1238, 0x123C; b_okuma_veri_blok_o = 0x00000044_00000033_00000022_00000011; b_okuma_istek_hazir_o high 1 cycle, 5 cycles after acceptance.
- Data write of block 0xDDDD_CCCC_BBBB_AAAA (per word) to 0x100 -> four writes with yaz=1 and data 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD at 0x100..0x10C; v_istek_hazir_o pulses; b_okuma_istek_hazir_o stays 0.
- Both valids high in the same BOSTA cycle twice in a row -> data cache served first, then instruction cache, each with exactly one hazir pulse.
- Memory inserts 3 wait cycles on word 2 -> address 0x...8 held stable for 4 cycles; hazir delayed 3 cycles; block correct.
- rst_i asserted during word 1 of a read -> no hazir; all outputs 0 next cycle; a new request afterwards completes normally.
- Requester holds valid one cycle past hazir -> a second full transaction is performed, no deadlock.
